async_fifo_flagged: RTL and testbench

//  Parametrised dual-clock FIFO with internal storage, Gray-coded pointer CDC and per-domain fill levels.

---
 rtl/async_fifo_flagged_if.sv | 42 ++++
 rtl/async_fifo_flagged.sv | 146 ++++++++++++++
 tb/tb_async_fifo_flagged.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/async_fifo_flagged_if.sv
// Bus bundle for the dual-clock flagged FIFO.
// master drives requests and thresholds; slave is the FIFO.
`timescale 1ns/100ps
interface async_fifo_flagged_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W:0]   af_thresh;
  logic              wr_clr_err;
  logic              full;
  logic              almost_full;
  logic [ADDR_W:0]   wr_level;
  logic              overflow;

  logic              rd_en;
  logic [ADDR_W:0]   ae_thresh;
  logic              rd_clr_err;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              empty;
  logic              almost_empty;
  logic [ADDR_W:0]   rd_level;
  logic              underflow;

  modport master (
    output wr_en, wr_data, af_thresh, wr_clr_err,
    input  full, almost_full, wr_level, overflow,
    output rd_en, ae_thresh, rd_clr_err,
    input  rd_data, rd_valid, empty, almost_empty,
    input  rd_level, underflow
  );

  modport slave (
    input  wr_en, wr_data, af_thresh, wr_clr_err,
    output full, almost_full, wr_level, overflow,
    input  rd_en, ae_thresh, rd_clr_err,
    output rd_data, rd_valid, empty, almost_empty,
    output rd_level, underflow
  );
endinterface

// File: rtl/async_fifo_flagged.sv
// Dual-clock FIFO, Gray pointer CDC, per-domain levels,
// almost flags and sticky overflow/underflow.
`timescale 1ns/100ps
module async_fifo_flagged #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10,
  parameter int SYNC_STAGES = 2
) (
  input logic wr_clk,
  input logic rd_clk,
  input logic rst_n,
  async_fifo_flagged_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef logic [ADDR_W:0] ptr_t;

  function automatic ptr_t b2g(ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t g2b(ptr_t g);
    ptr_t b;
    b[ADDR_W] = g[ADDR_W];
    for (int i = ADDR_W - 1; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  // Async assert, release synchronised to each domain
  logic [1:0] wr_rs;
  logic [1:0] rd_rs;
  logic       wr_rst_n;
  logic       rd_rst_n;

  always_ff @(posedge wr_clk or negedge rst_n)
    if (!rst_n) wr_rs <= '0;
    else        wr_rs <= {wr_rs[0], 1'b1};

  always_ff @(posedge rd_clk or negedge rst_n)
    if (!rst_n) rd_rs <= '0;
    else        rd_rs <= {rd_rs[0], 1'b1};

  assign wr_rst_n = wr_rs[1];
  assign rd_rst_n = rd_rs[1];

  ptr_t wr_bin, wr_gray;
  ptr_t rd_bin, rd_gray;
  ptr_t rs_q [SYNC_STAGES];
  ptr_t ws_q [SYNC_STAGES];
  ptr_t rg_s, wg_s;

  always_ff @(posedge wr_clk or negedge wr_rst_n)
    if (!wr_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        rs_q[i] <= '0;
    end else begin
      rs_q[0] <= rd_gray;
      for (int i = 1; i < SYNC_STAGES; i++)
        rs_q[i] <= rs_q[i-1];
    end

  always_ff @(posedge rd_clk or negedge rd_rst_n)
    if (!rd_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        ws_q[i] <= '0;
    end else begin
      ws_q[0] <= wr_gray;
      for (int i = 1; i < SYNC_STAGES; i++)
        ws_q[i] <= ws_q[i-1];
    end

  assign rg_s = rs_q[SYNC_STAGES-1];
  assign wg_s = ws_q[SYNC_STAGES-1];

  // Write domain
  logic wr_full;
  logic wr_go;
  logic ovf;
  ptr_t wr_lvl;

  assign wr_full = wr_gray ==
    {~rg_s[ADDR_W:ADDR_W-1], rg_s[ADDR_W-2:0]};
  assign wr_go  = bus.wr_en & ~wr_full & wr_rst_n;
  assign wr_lvl = wr_bin - g2b(rg_s);

  always_ff @(posedge wr_clk or negedge wr_rst_n)
    if (!wr_rst_n) begin
      wr_bin  <= '0;
      wr_gray <= '0;
      ovf     <= 1'b0;
    end else begin
      if (wr_go) begin
        wr_bin  <= wr_bin + 1'b1;
        wr_gray <= b2g(wr_bin + 1'b1);
      end
      if (bus.wr_en && wr_full) ovf <= 1'b1;
      else if (bus.wr_clr_err)  ovf <= 1'b0;
    end

  always_ff @(posedge wr_clk)
    if (wr_go) mem[wr_bin[ADDR_W-1:0]] <= bus.wr_data;

  // Read domain
  logic              rd_empty;
  logic              rd_go;
  logic              unf;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  ptr_t              rd_lvl;

  assign rd_empty = rd_gray == wg_s;
  assign rd_go    = bus.rd_en & ~rd_empty & rd_rst_n;
  assign rd_lvl   = g2b(wg_s) - rd_bin;

  always_ff @(posedge rd_clk or negedge rd_rst_n)
    if (!rd_rst_n) begin
      rd_bin  <= '0;
      rd_gray <= '0;
      rdata   <= '0;
      rvalid  <= 1'b0;
      unf     <= 1'b0;
    end else begin
      rvalid <= rd_go;
      if (rd_go) begin
        rdata   <= mem[rd_bin[ADDR_W-1:0]];
        rd_bin  <= rd_bin + 1'b1;
        rd_gray <= b2g(rd_bin + 1'b1);
      end
      if (bus.rd_en && rd_empty) unf <= 1'b1;
      else if (bus.rd_clr_err)   unf <= 1'b0;
    end

  assign bus.full         = wr_full;
  assign bus.almost_full  = wr_lvl >= bus.af_thresh;
  assign bus.wr_level     = wr_lvl;
  assign bus.overflow     = ovf;
  assign bus.rd_data      = rdata;
  assign bus.rd_valid     = rvalid;
  assign bus.empty        = rd_empty;
  assign bus.almost_empty = rd_lvl <= bus.ae_thresh;
  assign bus.rd_level     = rd_lvl;
  assign bus.underflow    = unf;
endmodule

// File: tb/tb_async_fifo_flagged.sv
// Bench for async_fifo_flagged: queue model, per-cycle
// flag/level/data checks and directed literal checks.
`timescale 1ns/100ps
module tb_async_fifo_flagged;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic wr_clk = 1'b0;
  logic rd_clk = 1'b0;
  logic rst_n  = 1'b1;

  async_fifo_flagged_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

  async_fifo_flagged #(
    .DATA_W(DW), .ADDR_W(AW), .SYNC_STAGES(2)
  ) dut (
    .wr_clk(wr_clk),
    .rd_clk(rd_clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 wr_clk = ~wr_clk;
  initial begin
    #1.3;
    forever #7.5 rd_clk = ~rd_clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] q[$];
  int            cnt   = 0;
  logic          m_val = 1'b0;
  logic [DW-1:0] m_dat = '0;
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: occupancy, order, sticky errors
  always @(negedge rst_n) begin
    q.delete();
    cnt   = 0;
    m_val = 1'b0;
    m_dat = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  end

  always @(posedge wr_clk) if (rst_n) begin
    if (bus.wr_en && !bus.full) begin
      q.push_back(bus.wr_data);
      cnt++;
    end
    if (bus.wr_en && bus.full)  m_ovf = 1'b1;
    else if (bus.wr_clr_err)    m_ovf = 1'b0;
  end

  always @(posedge rd_clk) if (rst_n) begin
    m_val = 1'b0;
    if (bus.rd_en && !bus.empty) begin
      chk("pop_nonempty", q.size() > 0, 1);
      if (q.size() > 0) m_dat = q.pop_front();
      m_val = 1'b1;
      cnt--;
    end
    if (bus.rd_en && bus.empty) m_unf = 1'b1;
    else if (bus.rd_clr_err)    m_unf = 1'b0;
  end

  always @(negedge wr_clk or negedge rd_clk) begin
    chk("no_x", $isunknown({bus.full, bus.almost_full,
        bus.wr_level, bus.overflow, bus.rd_data,
        bus.rd_valid, bus.empty, bus.almost_empty,
        bus.rd_level, bus.underflow}), 0);
    chk("wr_level_max", bus.wr_level <= DEPTH, 1);
    chk("wr_level_ge_cnt", int'(bus.wr_level) >= cnt, 1);
    chk("rd_level_le_cnt", int'(bus.rd_level) <= cnt, 1);
    chk("full", bus.full, bus.wr_level == DEPTH);
    chk("almost_full", bus.almost_full,
        bus.wr_level >= bus.af_thresh);
    chk("empty", bus.empty, bus.rd_level == 0);
    chk("almost_empty", bus.almost_empty,
        bus.rd_level <= bus.ae_thresh);
    chk("overflow", bus.overflow, m_ovf);
    chk("underflow", bus.underflow, m_unf);
    chk("rd_valid", bus.rd_valid, m_val);
    chk("rd_data", bus.rd_data, m_dat);
  end

  task automatic wr_cyc(input logic [DW-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    @(posedge wr_clk);
    #1;
    bus.wr_en = 1'b0;
  endtask

  task automatic rd_cyc();
    bus.rd_en = 1'b1;
    @(posedge rd_clk);
    #1;
    bus.rd_en = 1'b0;
  endtask

  task automatic settle();
    repeat (4) @(posedge wr_clk);
    repeat (4) @(posedge rd_clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    bus.wr_en      = 1'b0;
    bus.wr_data    = '0;
    bus.af_thresh  = 5'd12;
    bus.wr_clr_err = 1'b0;
    bus.rd_en      = 1'b0;
    bus.ae_thresh  = 5'd3;
    bus.rd_clr_err = 1'b0;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_empty", bus.empty, 1);
    chk("rst_aempty", bus.almost_empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_afull", bus.almost_full, 0);
    chk("rst_wr_level", bus.wr_level, 0);
    chk("rst_rd_level", bus.rd_level, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_unf", bus.underflow, 0);
    #30 rst_n = 1'b1;
    settle();

    // Fill 0..15, almost_full at 12, then overflow
    for (int i = 0; i < 16; i++) begin
      wr_cyc(i);
      if (i == 10) chk("afull_at_11", bus.almost_full, 0);
      if (i == 11) chk("afull_at_12", bus.almost_full, 1);
    end
    chk("full_16", bus.full, 1);
    chk("wr_level_16", bus.wr_level, 16);
    wr_cyc(32'hDEAD_BEEF);
    chk("ovf_set", bus.overflow, 1);
    chk("wr_level_keep", bus.wr_level, 16);
    bus.wr_clr_err = 1'b1;
    @(posedge wr_clk);
    #1 bus.wr_clr_err = 1'b0;
    chk("ovf_clr", bus.overflow, 0);

    // Drain 0..15, almost_empty at 3, then underflow
    settle();
    chk("rd_level_16", bus.rd_level, 16);
    for (int i = 0; i < 16; i++) begin
      rd_cyc();
      chk("drain_valid", bus.rd_valid, 1);
      chk("drain_data", bus.rd_data, i);
      if (i == 11) chk("aempty_at_4", bus.almost_empty, 0);
      if (i == 12) begin
        chk("rd_level_3", bus.rd_level, 3);
        chk("aempty_at_3", bus.almost_empty, 1);
      end
    end
    chk("empty_after", bus.empty, 1);
    chk("rd_level_0", bus.rd_level, 0);
    rd_cyc();
    chk("unf_set", bus.underflow, 1);
    chk("unf_no_valid", bus.rd_valid, 0);
    chk("unf_hold_data", bus.rd_data, 15);
    bus.rd_clr_err = 1'b1;
    @(posedge rd_clk);
    #1 bus.rd_clr_err = 1'b0;
    chk("unf_clr", bus.underflow, 0);
    settle();
    chk("wr_level_0", bus.wr_level, 0);
    chk("full_clear", bus.full, 0);

    // Single-word latency
    wr_cyc(32'hABCD_1234);
    k = 0;
    while (bus.empty && k < 6) begin
      @(posedge rd_clk);
      #1 k++;
    end
    chk("empty_latency_ok", (k <= 3) && !bus.empty, 1);
    rd_cyc();
    chk("lat_valid", bus.rd_valid, 1);
    chk("lat_data", bus.rd_data, 32'hABCD_1234);

    // Random streaming, 1000 words
    fork
      begin
        int sent = 0;
        int cyc  = 0;
        while (sent < 1000 && cyc < 20000) begin
          cyc++;
          if (!bus.full && $urandom_range(0, 99) < 60) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = $urandom;
            sent++;
          end else begin
            bus.wr_en = 1'b0;
          end
          @(posedge wr_clk);
          #1;
        end
        bus.wr_en = 1'b0;
        chk("stream_sent", sent, 1000);
      end
      begin
        int got = 0;
        int cyc = 0;
        while (got < 1000 && cyc < 40000) begin
          cyc++;
          bus.rd_en = !bus.empty &&
                      ($urandom_range(0, 99) < 50);
          @(posedge rd_clk);
          #1;
          if (bus.rd_valid) got++;
        end
        bus.rd_en = 1'b0;
        chk("stream_got", got, 1000);
      end
    join
    chk("stream_ovf", bus.overflow, 0);
    chk("stream_unf", bus.underflow, 0);

    // Reset flush with 8 stored words and an error set
    settle();
    rd_cyc();
    chk("pre_rst_unf", bus.underflow, 1);
    for (int i = 0; i < 8; i++) wr_cyc(100 + i);
    settle();
    chk("pre_rst_level", bus.rd_level, 8);
    #3 rst_n = 1'b0;
    #1;
    chk("flush_empty", bus.empty, 1);
    chk("flush_full", bus.full, 0);
    chk("flush_wr_level", bus.wr_level, 0);
    chk("flush_rd_level", bus.rd_level, 0);
    chk("flush_ovf", bus.overflow, 0);
    chk("flush_unf", bus.underflow, 0);
    chk("flush_valid", bus.rd_valid, 0);
    #20 rst_n = 1'b1;
    settle();
    wr_cyc(32'h5555_0001);
    settle();
    chk("new_level", bus.rd_level, 1);
    rd_cyc();
    chk("new_valid", bus.rd_valid, 1);
    chk("new_data", bus.rd_data, 32'h5555_0001);
    settle();
    chk("new_empty", bus.empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
